clk_divider_multi: RTL and testbench

Parametrised, runtime-programmable clock divider producing NUM_CH independent divided clocks and single-cycle rising-edge tick strobes from one input clock. Used in FPGA board designs to slow observable logic (LEDs, displays, stepping FSMs) and to supply per-subsystem enable ticks. Each channel's half-period is reprogrammable through a valid/ready handshake. A new value takes effect only at a toggle boundary, so no runt pulses are ever produced.

---
 rtl/clk_divider_pkg.sv | 22 ++
 rtl/clk_divider_multi_if.sv | 19 +
 rtl/clk_divider_channel.sv | 62 ++++++
 rtl/clk_divider_multi.sv | 86 ++++++++
 tb/tb_clk_divider_multi.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/clk_divider_pkg.sv
// clk_divider_pkg: shared constants, channel-id width helper and the update record
// used by clk_divider_multi and its handshake interface.
package clk_divider_pkg;

  localparam int unsigned CNT_W_DEF        = 26;
  localparam int unsigned DEFAULT_HALF_DEF = 25000000;
  localparam int unsigned MAX_CH           = 16;
  localparam int unsigned MAX_CH_W         = 4;
  localparam int unsigned MAX_CNT_W        = 32;

  // Channel-index width, never below one bit
  function automatic int unsigned chWidth(input int unsigned numCh);
    return (numCh > 1) ? $clog2(numCh) : 1;
  endfunction

  // Divisor update record held in the shadow slot
  typedef struct packed {
    logic [MAX_CH_W-1:0]  ch;
    logic [MAX_CNT_W-1:0] value;
  } updRec_t;

endpackage

// File: rtl/clk_divider_multi_if.sv
// clk_divider_multi_if: divisor update valid/ready handshake.
interface clk_divider_multi_if
  import clk_divider_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = CNT_W_DEF
);

  localparam int unsigned CH_W = chWidth(NUM_CH);

  logic             div_valid;
  logic [CH_W-1:0]  div_ch;
  logic [CNT_W-1:0] div_value;
  logic             div_ready;

  modport master (output div_valid, div_ch, div_value, input div_ready);
  modport slave  (input div_valid, div_ch, div_value, output div_ready);

endinterface

// File: rtl/clk_divider_channel.sv
// clk_divider_channel: one divider channel (counter, half-period register,
// divided clock and rising-edge tick). Tick logic exists only when
// CLK_DIVIDER_TICK_EN is defined; otherwise tick is tied low.
module clk_divider_channel #(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned DEFAULT_HALF = 3
) (
  input  logic             inClk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             wrap,
  output logic             outClk,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half;

  // Wrap edge: the counter has reached (or passed) the current half-period
  assign wrap = en && (cnt >= half);

  // Half-period counter and divided clock; disable clears both at once
  always_ff @(posedge inClk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      outClk <= 1'b0;
    end else if (!en) begin
      cnt    <= '0;
      outClk <= 1'b0;
    end else if (wrap) begin
      cnt    <= '0;
      outClk <= ~outClk;
    end else begin
      cnt    <= cnt + CNT_W'(1);
    end
  end

  // Half-period register; the top only pulses load on a safe boundary
  always_ff @(posedge inClk or negedge reset) begin
    if (!reset) begin
      half <= CNT_W'(DEFAULT_HALF);
    end else if (load) begin
      half <= load_value;
    end
  end

`ifdef CLK_DIVIDER_TICK_EN
  // Tick coincides with every 0->1 of outClk
  always_ff @(posedge inClk or negedge reset) begin
    if (!reset) begin
      tick <= 1'b0;
    end else begin
      tick <= wrap & ~outClk;
    end
  end
`else
  assign tick = 1'b0;
`endif

endmodule

// File: rtl/clk_divider_multi.sv
// clk_divider_multi: NUM_CH runtime-programmable clock dividers sharing one
// shadow update slot. Optional tick strobes are built under CLK_DIVIDER_TICK_EN.
module clk_divider_multi
  import clk_divider_pkg::*;
#(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF
) (
  input  logic              inClk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  clk_divider_multi_if.slave divBus,
  output logic [NUM_CH-1:0] outClk,
  output logic [NUM_CH-1:0] tick
);

  // Elaboration-time parameter sanity
  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : gBadNumCh
    $error("clk_divider_multi: NUM_CH must be 1..16");
  end
  if (CNT_W < 1 || CNT_W > MAX_CNT_W) begin : gBadCntW
    $error("clk_divider_multi: CNT_W must be 1..32");
  end
  if (64'(DEFAULT_HALF) >= (64'd1 << CNT_W)) begin : gBadDefault
    $error("clk_divider_multi: DEFAULT_HALF does not fit in CNT_W");
  end

  logic              pending;
  updRec_t           shadow;
  logic              xfer;
  logic              inRange;
  logic              applyAny;
  logic [NUM_CH-1:0] loadVec;
  logic [NUM_CH-1:0] wrapVec;
  logic              unusedShadow;

  // Single shadow slot: ready whenever nothing is pending
  assign divBus.div_ready = ~pending;
  assign xfer             = divBus.div_valid & ~pending;
  assign inRange          = (32'(divBus.div_ch) < NUM_CH);
  assign applyAny         = |loadVec;
  assign unusedShadow     = ^shadow.value;

  // Steer the pending update: at the next wrap if running, else right away
  always_comb begin
    loadVec = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      loadVec[i] = pending && (shadow.ch == MAX_CH_W'(i)) && (!en[i] || wrapVec[i]);
    end
  end

  // Capture accepted updates; out-of-range ids complete but are dropped
  always_ff @(posedge inClk or negedge reset) begin
    if (!reset) begin
      pending <= 1'b0;
      shadow  <= '0;
    end else if (xfer) begin
      if (inRange) begin
        pending      <= 1'b1;
        shadow.ch    <= MAX_CH_W'(divBus.div_ch);
        shadow.value <= MAX_CNT_W'(divBus.div_value);
      end
    end else if (applyAny) begin
      pending <= 1'b0;
    end
  end

  // One divider per channel
  for (genvar g = 0; g < int'(NUM_CH); g++) begin : gCh
    clk_divider_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) uCh (
      .inClk      (inClk),
      .reset      (reset),
      .en         (en[g]),
      .load       (loadVec[g]),
      .load_value (CNT_W'(shadow.value)),
      .wrap       (wrapVec[g]),
      .outClk     (outClk[g]),
      .tick       (tick[g])
    );
  end

endmodule

// File: tb/tb_clk_divider_multi.sv
// tb_clk_divider_multi: directed checks of clk_divider_multi (CNT_W=8, DEFAULT_HALF=3).
// Tick expectations follow CLK_DIVIDER_TICK_EN; without it tick must stay 0.
module tb_clk_divider_multi;
  import clk_divider_pkg::*;

  localparam int unsigned NUM_CH       = 2;
  localparam int unsigned CNT_W        = 8;
  localparam int unsigned DEFAULT_HALF = 3;

  logic        inClk;
  logic        reset;
  logic [1:0]  en;
  logic [1:0]  outClk;
  logic [1:0]  tick;
  // div_ch is one bit at NUM_CH=2, so out-of-range ids use a 3-channel instance
  logic [2:0]  en3;
  logic [2:0]  outClk3;
  logic [2:0]  tick3;

  int nChecks = 0;
  int nBad    = 0;

  clk_divider_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) divBus ();
  clk_divider_multi_if #(.NUM_CH(3), .CNT_W(CNT_W)) divBus3 ();

  clk_divider_multi #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_HALF(DEFAULT_HALF)
  ) dut (
    .inClk(inClk), .reset(reset), .en(en), .divBus(divBus), .outClk(outClk), .tick(tick)
  );

  clk_divider_multi #(
    .NUM_CH(3), .CNT_W(CNT_W), .DEFAULT_HALF(DEFAULT_HALF)
  ) dut3 (
    .inClk(inClk), .reset(reset), .en(en3), .divBus(divBus3), .outClk(outClk3), .tick(tick3)
  );

  initial inClk = 1'b0;
  always #5 inClk = ~inClk;

  // Count one comparison and report it if it differs
  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] tickExp(input logic [2:0] t);
`ifdef CLK_DIVIDER_TICK_EN
    return t;
`else
    return 3'(t & 3'b000);
`endif
  endfunction

  // Advance one edge and settle
  task automatic step();
    @(posedge inClk);
    #1;
  endtask

  initial begin
    logic [15:0] pat;
    logic [15:0] tpat;
    logic [5:0]  pat2;
    logic [5:0]  tpat2;
    logic [1:0]  clk3 [6];
    logic [1:0]  tck3 [6];
    logic [7:0]  patB;

    pat   = 16'b0111_1000_0111_1000;  // outClk after edge k is bit k-1, half=3
    tpat  = 16'b0000_1000_0000_1000;
    pat2  = 6'b011001;                // edges 21..26, half=1
    tpat2 = 6'b001000;
    clk3  = '{2'b11, 2'b00, 2'b10, 2'b01, 2'b11, 2'b00};  // edges 29..34
    tck3  = '{2'b10, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00};
    patB  = 8'b1000_0111;             // dut3 ch0 after edges 5..12

    reset = 1'b0;
    en    = 2'b00;
    en3   = 3'b000;
    divBus.div_valid  = 1'b0;
    divBus.div_ch     = '0;
    divBus.div_value  = '0;
    divBus3.div_valid = 1'b0;
    divBus3.div_ch    = '0;
    divBus3.div_value = '0;

    // Reset state
    step();
    step();
    checkVal("rst outClk", 32'(outClk), 32'd0);
    checkVal("rst tick", 32'(tick), 32'd0);
    checkVal("rst ready", 32'(divBus.div_ready), 32'd1);

    // S1: channel 0 at default half, period 8
    reset = 1'b1;
    en    = 2'b01;
    for (int k = 1; k <= 16; k++) begin
      step();
      checkVal($sformatf("s1 outClk k%0d", k), 32'(outClk), 32'({1'b0, pat[k-1]}));
      checkVal($sformatf("s1 tick k%0d", k), 32'(tick), 32'(tickExp({2'b00, tpat[k-1]})));
    end

    // S2: update ch0 to half=1 mid-half-period
    step();  // edge 17
    divBus.div_valid = 1'b1;
    divBus.div_ch    = 1'b0;
    divBus.div_value = 8'd1;
    step();  // edge 18: transfer
    divBus.div_valid = 1'b0;
    checkVal("s2 ready e18", 32'(divBus.div_ready), 32'd0);
    checkVal("s2 outClk e18", 32'(outClk), 32'd0);
    step();
    checkVal("s2 ready e19", 32'(divBus.div_ready), 32'd0);
    checkVal("s2 outClk e19", 32'(outClk), 32'd0);
    step();  // edge 20: wrap with old half, apply
    checkVal("s2 ready e20", 32'(divBus.div_ready), 32'd1);
    checkVal("s2 outClk e20", 32'(outClk), 32'd1);
    checkVal("s2 tick e20", 32'(tick), 32'(tickExp(3'b001)));
    for (int k = 0; k < 6; k++) begin
      step();
      checkVal($sformatf("s2 outClk e%0d", 21 + k), 32'(outClk), 32'({1'b0, pat2[k]}));
      checkVal($sformatf("s2 tick e%0d", 21 + k), 32'(tick), 32'(tickExp({2'b00, tpat2[k]})));
    end

    // S3: update disabled ch1 to half=0, then enable it
    divBus.div_valid = 1'b1;
    divBus.div_ch    = 1'b1;
    divBus.div_value = 8'd0;
    step();  // edge 27: transfer
    divBus.div_valid = 1'b0;
    checkVal("s3 ready e27", 32'(divBus.div_ready), 32'd0);
    step();  // edge 28: applied to disabled channel
    checkVal("s3 ready e28", 32'(divBus.div_ready), 32'd1);
    en = 2'b11;
    for (int k = 0; k < 6; k++) begin
      step();
      checkVal($sformatf("s3 outClk e%0d", 29 + k), 32'(outClk), 32'(clk3[k]));
      checkVal($sformatf("s3 tick e%0d", 29 + k), 32'(tick), 32'(tickExp({1'b0, tck3[k]})));
    end

    // S5: reset mid-half-period with an update pending
    divBus.div_valid = 1'b1;
    divBus.div_ch    = 1'b0;
    divBus.div_value = 8'd1;
    step();  // edge 35
    divBus.div_valid = 1'b0;
    checkVal("s5 ready pre", 32'(divBus.div_ready), 32'd0);
    checkVal("s5 outClk pre", 32'(outClk), 32'd2);
    reset = 1'b0;
    #1;
    checkVal("s5 outClk async", 32'(outClk), 32'd0);
    checkVal("s5 tick async", 32'(tick), 32'd0);
    checkVal("s5 ready async", 32'(divBus.div_ready), 32'd1);
    step();
    step();
    reset = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      checkVal($sformatf("s5 outClk k%0d", k), 32'(outClk), 32'({pat[k-1], pat[k-1]}));
      checkVal($sformatf("s5 tick k%0d", k), 32'(tick), 32'(tickExp({1'b0, tpat[k-1], tpat[k-1]})));
    end

    // S4: request held while pending, then an out-of-range id is dropped
    en3 = 3'b001;
    divBus3.div_valid = 1'b1;
    divBus3.div_ch    = 2'd0;
    divBus3.div_value = 8'd3;
    step();  // edge 1: transfer
    divBus3.div_ch    = 2'd3;
    divBus3.div_value = 8'd0;
    checkVal("s4 ready e1", 32'(divBus3.div_ready), 32'd0);
    step();
    checkVal("s4 ready e2", 32'(divBus3.div_ready), 32'd0);
    step();
    checkVal("s4 ready e3", 32'(divBus3.div_ready), 32'd0);
    step();  // edge 4: ch0 wraps, apply
    checkVal("s4 ready e4", 32'(divBus3.div_ready), 32'd1);
    checkVal("s4 outClk e4", 32'(outClk3), 32'd1);
    step();  // edge 5: out-of-range transfer
    divBus3.div_valid = 1'b0;
    checkVal("s4 ready e5", 32'(divBus3.div_ready), 32'd1);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      checkVal($sformatf("s4 outClk e%0d", 5 + k), 32'(outClk3), 32'({2'b00, patB[k]}));
      checkVal($sformatf("s4 ready e%0d", 5 + k), 32'(divBus3.div_ready), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

  // Run-time bound
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
